// File: rtl/bldc_comm_seq.sv
// Sensorless BLDC commutation sequencer: rotor align, open-loop period ramp,
// then closed-loop commutation on filtered back-EMF zero crossings.
module bldc_comm_seq #(
    parameter int DUTY_DW = 12,
    parameter int PER_DW  = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [PER_DW-1:0]  align_time_i,
    input  logic [PER_DW-1:0]  ramp_start_per_i,
    input  logic [PER_DW-1:0]  ramp_end_per_i,
    input  logic [PER_DW-1:0]  ramp_step_i,
    input  logic [DUTY_DW-1:0] duty_align_i,
    input  logic [DUTY_DW-1:0] duty_run_i,
    input  logic               zc_i,
    input  logic               pwm_middle_i,
    output logic [2:0]         comm_o,
    output logic [DUTY_DW-1:0] duty_o,
    output logic               pwm_en_o,
    output logic [2:0]         state_o,
    output logic               locked_o,
    output logic               fault_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          comm_q, comm_d;
    logic [DUTY_DW-1:0]  duty_q, duty_d;
    logic                pwm_en_q, pwm_en_d;
    logic                locked_q, locked_d;
    logic                fault_q, fault_d;
    logic [PER_DW-1:0]   timer_q, timer_d;
    logic [PER_DW-1:0]   per_q, per_d;
    logic [PER_DW:0]     t_q, t_d;
    logic [PER_DW:0]     dly_q, dly_d;
    logic [1:0]          filt_q, filt_d;
    logic                zc_seen_q, zc_seen_d;
    logic                mid_q;
    logic [PER_DW-1:0]   ramp_start_q, ramp_start_d;
    logic [PER_DW-1:0]   ramp_end_q, ramp_end_d;
    logic [PER_DW-1:0]   ramp_step_q, ramp_step_d;
    logic [DUTY_DW-1:0]  duty_run_q, duty_run_d;

    logic                mid_rise_s;
    logic                zc_match_s;
    logic [PER_DW:0]     per_diff_s;
    logic [PER_DW-1:0]   per_sat_s;

    function automatic logic [2:0] next_comm(input logic [2:0] c);
        if (c >= 3'd6) begin
            return 3'd1;
        end else begin
            return c + 3'd1;
        end
    endfunction

    // Mid-pulse edge detect, ZC polarity match and saturated ramp period
    always_comb begin
        mid_rise_s = pwm_middle_i & ~mid_q;
        zc_match_s = (zc_i == comm_q[0]);
        per_diff_s = {1'b0, per_q} - {1'b0, ramp_step_q};
        if (per_diff_s[PER_DW] || (per_diff_s[PER_DW-1:0] < ramp_end_q)) begin
            per_sat_s = ramp_end_q;
        end else begin
            per_sat_s = per_diff_s[PER_DW-1:0];
        end
    end

    // Next-state and next-output logic; stop_i overrides everything
    always_comb begin
        state_d      = state_q;
        comm_d       = comm_q;
        duty_d       = duty_q;
        pwm_en_d     = pwm_en_q;
        locked_d     = locked_q;
        fault_d      = fault_q;
        timer_d      = timer_q;
        per_d        = per_q;
        t_d          = t_q;
        dly_d        = dly_q;
        filt_d       = filt_q;
        zc_seen_d    = zc_seen_q;
        ramp_start_d = ramp_start_q;
        ramp_end_d   = ramp_end_q;
        ramp_step_d  = ramp_step_q;
        duty_run_d   = duty_run_q;

        if (stop_i) begin
            state_d   = S_IDLE;
            comm_d    = 3'd0;
            duty_d    = '0;
            pwm_en_d  = 1'b0;
            locked_d  = 1'b0;
            fault_d   = 1'b0;
            timer_d   = '0;
            per_d     = '0;
            t_d       = '0;
            dly_d     = '0;
            filt_d    = 2'd0;
            zc_seen_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d      = S_ALIGN;
                        comm_d       = 3'd1;
                        duty_d       = duty_align_i;
                        pwm_en_d     = 1'b1;
                        timer_d      = align_time_i;
                        ramp_start_d = ramp_start_per_i;
                        ramp_end_d   = ramp_end_per_i;
                        ramp_step_d  = ramp_step_i;
                        duty_run_d   = duty_run_i;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ALIGN: begin
                    if (timer_q == '0) begin
                        state_d = S_RAMP;
                        comm_d  = 3'd2;
                        duty_d  = duty_run_q;
                        per_d   = ramp_start_q;
                        timer_d = ramp_start_q;
                    end else begin
                        timer_d = timer_q - PER_DW'(1);
                    end
                end
                S_RAMP: begin
                    if (timer_q == '0) begin
                        comm_d  = next_comm(comm_q);
                        per_d   = per_sat_s;
                        timer_d = per_sat_s;
                        // Period already at (or below) the floor: hand over to closed loop
                        if (per_q <= ramp_end_q) begin
                            state_d   = S_RUN;
                            locked_d  = 1'b1;
                            t_d       = '0;
                            dly_d     = '0;
                            filt_d    = 2'd0;
                            zc_seen_d = 1'b0;
                        end else begin
                            state_d = S_RAMP;
                        end
                    end else begin
                        timer_d = timer_q - PER_DW'(1);
                    end
                end
                S_RUN: begin
                    if (t_q != '1) begin
                        t_d = t_q + (PER_DW+1)'(1);
                    end else begin
                        t_d = t_q;
                    end
                    if (zc_seen_q) begin
                        // Mirror the measured ZC time: commutate once it has elapsed again
                        if (dly_q == '0) begin
                            comm_d    = next_comm(comm_q);
                            t_d       = '0;
                            filt_d    = 2'd0;
                            zc_seen_d = 1'b0;
                        end else begin
                            dly_d = dly_q - (PER_DW+1)'(1);
                        end
                    end else if (mid_rise_s && zc_match_s && (filt_q == 2'd1)) begin
                        zc_seen_d = 1'b1;
                        dly_d     = t_q;
                        filt_d    = 2'd0;
                    end else begin
                        if (mid_rise_s) begin
                            filt_d = zc_match_s ? (filt_q + 2'd1) : 2'd0;
                        end else begin
                            filt_d = filt_q;
                        end
                        if (t_q >= {ramp_end_q, 1'b0}) begin
                            state_d  = S_FAULT;
                            comm_d   = 3'd0;
                            duty_d   = '0;
                            pwm_en_d = 1'b0;
                            locked_d = 1'b0;
                            fault_d  = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d   = S_IDLE;
                    comm_d    = 3'd0;
                    duty_d    = '0;
                    pwm_en_d  = 1'b0;
                    locked_d  = 1'b0;
                    fault_d   = 1'b0;
                    zc_seen_d = 1'b0;
                end
            endcase
        end
    end

    // State, output and timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            comm_q       <= 3'd0;
            duty_q       <= '0;
            pwm_en_q     <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            timer_q      <= '0;
            per_q        <= '0;
            t_q          <= '0;
            dly_q        <= '0;
            filt_q       <= 2'd0;
            zc_seen_q    <= 1'b0;
            mid_q        <= 1'b0;
            ramp_start_q <= '0;
            ramp_end_q   <= '0;
            ramp_step_q  <= '0;
            duty_run_q   <= '0;
        end else begin
            state_q      <= state_d;
            comm_q       <= comm_d;
            duty_q       <= duty_d;
            pwm_en_q     <= pwm_en_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
            timer_q      <= timer_d;
            per_q        <= per_d;
            t_q          <= t_d;
            dly_q        <= dly_d;
            filt_q       <= filt_d;
            zc_seen_q    <= zc_seen_d;
            mid_q        <= pwm_middle_i;
            ramp_start_q <= ramp_start_d;
            ramp_end_q   <= ramp_end_d;
            ramp_step_q  <= ramp_step_d;
            duty_run_q   <= duty_run_d;
        end
    end

    assign comm_o   = comm_q;
    assign duty_o   = duty_q;
    assign pwm_en_o = pwm_en_q;
    assign state_o  = state_q;
    assign locked_o = locked_q;
    assign fault_o  = fault_q;

endmodule
